fp16_mul_post: RTL and testbench
================================

Name: fp16_mul_post

Overview:
- Operand front-end and result back-end for the FP16 significand multiplier `booth_multiplier`.
- Unpacks two IEEE-754 binary16 operands and drives the multiplier's a/b/azero/bzero inputs.
- Carries sign, exponent and special-case information alongside the multiplier's one-cycle latency.
- Consumes the 24-bit product, then normalises, rounds (RNE), packs and flags the result. Fully pipelined: one operation per cycle, no backpressure.

Parameters:
- BIAS, 15, exponent bias.
- QNAN, 16'h7E00, canonical NaN returned for every NaN result.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all in-flight valids
- op_valid  input  1  op_a/op_b valid this cycle
- op_a  input  16  binary16 operand A
- op_b  input  16  binary16 operand B
- mul_a  output  10  op_a[9:0], combinational, to multiplier a
- mul_b  output  10  op_b[9:0], combinational, to multiplier b
- mul_azero  output  1  hidden bit of A = (op_a[14:10]!=0), to multiplier azero
- mul_bzero  output  1  hidden bit of B, to multiplier bzero
- mul_s  input  24  multiplier product s, valid one cycle after op issue
- res_valid  output  1  result valid
- res  output  16  binary16 product
- flag_ovf  output  1  overflow to infinity
- flag_unf  output  1  underflow flushed to zero
- flag_inx  output  1  inexact
- flag_inv  output  1  invalid (NaN produced from non-NaN inputs, inf*0)

Behaviour:
- Reset (RST=0, async): res_valid=0, res=16'h0000, all flags 0, all pipeline valids 0, side-band regs 0.
- Latency: op_valid at edge T produces res_valid=1 at T+3. Back-to-back issue is supported.
- Stage 0, registered at T+1 alongside mul_s. Side-band holds:
  - sign = sa^sb;
  - signed 7-bit esum = ea_eff+eb_eff-BIAS, where e_eff = exp, or 1 when exp==0;
  - special class: nan_in, inf_in, zero_in, inv = (inf&zero across operands).
- Product format (decided): P = mul_s[21:0], unsigned, binary point between bits 20 and 19; mul_s[23:22] are 0.
- Stage 1, registered at T+2 (normalise):
  - P[21]=1: shift right 1, e=esum+1, fold the shifted-out bit into sticky.
  - Else: left-shift by lzc(P[20:0]) so bit 20 is set, e = esum-lzc. lzc range 0..20, nonzero only when a subnormal input is present.
  - Keep a 10-bit fraction, guard bit and sticky = OR of all lower bits.
- Stage 2, registered at T+3 (round and pack):
  - RNE: increment when guard & (sticky | lsb).
  - Fraction carry-out: fraction becomes 0, e+1.
  - inx = guard|sticky.
- Result priority, highest first:
  1. nan_in or inv: res=QNAN; inv sets flag_inv.
  2. inf_in: res={sign,5'h1F,10'h0}.
  3. zero_in or P==0: res={sign,15'h0}, no flags.
  4. e>=31 after rounding: res={sign,5'h1F,10'h0}, flag_ovf=1, flag_inx=1.
  5. e<=0 (flush-to-zero, no subnormal outputs): res={sign,15'h0}, flag_unf=1, flag_inx=1.
  6. Otherwise: {sign,e[4:0],frac}, flag_inx=inx.
- Flags are valid only with res_valid. res and flags hold their last value while res_valid=0.
- flush=1: all stage valids clear at the next edge, res_valid=0 the cycle after. An op_valid in the same cycle as flush is dropped.
- RST asserted mid-stream: in-flight operations are discarded immediately. The first result after release appears 3 cycles after the next op_valid.
- mul_* outputs are pure combinational decode of op_a/op_b and are independent of op_valid.

Test Plan:
- 0x3C00*0x4000, then 0x3E00*0x3E00, then 0x3C01*0x3C01, issued back-to-back from T → res 0x4000 @T+3, 0x4080 @T+4, 0x3C02 @T+5 (only the last has flag_inx=1); res_valid high for exactly 3 cycles.
- 0x0200*0x4800 (subnormal input, lzc=1) → res=0x0C00, no flags. 0x0400*0x3800 → 0x0000 with flag_unf=1, flag_inx=1. 0x8400*0x3800 → 0x8000 with flag_unf=1.
- 0x7BFF*0x7BFF → 0x7C00, flag_ovf=1, flag_inx=1. 0xFBFF*0x7BFF → 0xFC00 with the same flags.
- 0x7C00*0x0000 → 0x7E00, flag_inv=1. 0xFC00*0x3C00 → 0xFC00, no flags. 0x7C01*0x3C00 → 0x7E00, flag_inv=0. 0x8000*0x3C00 → 0x8000.
- Issue 4 ops on consecutive cycles; assert flush the cycle after the 2nd op's result → exactly 2 results are observed, res_valid=0 afterwards.
- Pull RST low asynchronously mid-clock with 3 ops in flight → res_valid and flags are 0 before the next edge. After release, a new 0x3C00*0x3C00 returns 0x3C00 3 cycles after issue.

Source files
------------

// File: rtl/fp16_mul_post.sv
// FP16 multiply wrapper around an external one-cycle significand multiplier:
// operand unpack, side-band pipeline, normalise, RNE round, pack and flags.
module fp16_mul_post #(
  parameter int          BIAS = 15,
  parameter logic [15:0] QNAN = 16'h7E00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [9:0]  mul_a,
  output logic [9:0]  mul_b,
  output logic        mul_azero,
  output logic        mul_bzero,
  input  logic [23:0] mul_s,
  output logic        res_valid,
  output logic [15:0] res,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inx,
  output logic        flag_inv
);

  logic [15:0] op_w [2];
  logic [1:0]  hidden, is_nan, is_inf, is_zero;
  logic [4:0]  e_eff [2];

  assign op_w[0] = op_a;
  assign op_w[1] = op_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dec
      assign hidden[gi]  = |op_w[gi][14:10];
      assign is_nan[gi]  = (&op_w[gi][14:10]) & (|op_w[gi][9:0]);
      assign is_inf[gi]  = (&op_w[gi][14:10]) & ~(|op_w[gi][9:0]);
      assign is_zero[gi] = ~(|op_w[gi][14:0]);
      assign e_eff[gi]   = hidden[gi] ? op_w[gi][14:10] : 5'd1;
    end
  endgenerate

  assign mul_a     = op_a[9:0];
  assign mul_b     = op_b[9:0];
  assign mul_azero = hidden[0];
  assign mul_bzero = hidden[1];

  logic signed [6:0] esum_next;
  assign esum_next = 7'(e_eff[0]) + 7'(e_eff[1]) - 7'(BIAS);

  // Stage 0: side-band aligned with the multiplier's registered product
  logic              s0_valid_reg, s0_sign_reg, s0_nan_reg, s0_inf_reg, s0_zero_reg, s0_inv_reg;
  logic signed [6:0] s0_esum_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0_valid_reg <= 1'b0;
      s0_sign_reg  <= 1'b0;
      s0_nan_reg   <= 1'b0;
      s0_inf_reg   <= 1'b0;
      s0_zero_reg  <= 1'b0;
      s0_inv_reg   <= 1'b0;
      s0_esum_reg  <= '0;
    end else begin
      s0_valid_reg <= op_valid & ~flush;
      s0_sign_reg  <= op_a[15] ^ op_b[15];
      s0_nan_reg   <= |is_nan;
      s0_inf_reg   <= |is_inf;
      s0_zero_reg  <= |is_zero;
      s0_inv_reg   <= (is_inf[0] & is_zero[1]) | (is_zero[0] & is_inf[1]);
      s0_esum_reg  <= esum_next;
    end
  end

  // Stage 1: normalise the product so the leading one lands on bit 20
  logic [21:0]       p;
  logic [4:0]        lzc;
  logic [19:0]       norm;
  logic [9:0]        frac1;
  logic              guard1, sticky1;
  logic signed [6:0] e1;

  assign p = mul_s[21:0];

  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 21; i++) begin
      if (p[i]) lzc = 5'(20 - i);
    end
    norm = p[19:0] << lzc;
    if (p[21]) begin
      frac1   = p[20:11];
      guard1  = p[10];
      sticky1 = |p[9:0];
      e1      = s0_esum_reg + 7'sd1;
    end else begin
      frac1   = norm[19:10];
      guard1  = norm[9];
      sticky1 = |norm[8:0];
      e1      = s0_esum_reg - $signed({2'b00, lzc});
    end
  end

  logic              s1_valid_reg, s1_sign_reg, s1_nan_reg, s1_inf_reg, s1_zero_reg, s1_inv_reg;
  logic              s1_guard_reg, s1_sticky_reg;
  logic [9:0]        s1_frac_reg;
  logic signed [6:0] s1_e_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid_reg  <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_nan_reg    <= 1'b0;
      s1_inf_reg    <= 1'b0;
      s1_zero_reg   <= 1'b0;
      s1_inv_reg    <= 1'b0;
      s1_guard_reg  <= 1'b0;
      s1_sticky_reg <= 1'b0;
      s1_frac_reg   <= '0;
      s1_e_reg      <= '0;
    end else begin
      s1_valid_reg  <= s0_valid_reg & ~flush;
      s1_sign_reg   <= s0_sign_reg;
      s1_nan_reg    <= s0_nan_reg;
      s1_inf_reg    <= s0_inf_reg;
      s1_zero_reg   <= s0_zero_reg | ~(|mul_s);
      s1_inv_reg    <= s0_inv_reg;
      s1_guard_reg  <= guard1;
      s1_sticky_reg <= sticky1;
      s1_frac_reg   <= frac1;
      s1_e_reg      <= e1;
    end
  end

  // Stage 2: round to nearest even, then resolve specials by priority
  logic [10:0]       sum;
  logic signed [6:0] e2;
  logic [15:0]       res_next;
  logic              ovf_next, unf_next, inx_next, inv_next;

  always_comb begin
    sum      = {1'b0, s1_frac_reg}
             + {10'b0, s1_guard_reg & (s1_sticky_reg | s1_frac_reg[0])};
    e2       = s1_e_reg + $signed({6'b0, sum[10]});
    res_next = {s1_sign_reg, e2[4:0], sum[9:0]};
    ovf_next = 1'b0;
    unf_next = 1'b0;
    inx_next = s1_guard_reg | s1_sticky_reg;
    inv_next = 1'b0;
    if (s1_nan_reg | s1_inv_reg) begin
      res_next = QNAN;
      inx_next = 1'b0;
      inv_next = s1_inv_reg;
    end else if (s1_inf_reg) begin
      res_next = {s1_sign_reg, 5'h1F, 10'h0};
      inx_next = 1'b0;
    end else if (s1_zero_reg) begin
      res_next = {s1_sign_reg, 15'h0};
      inx_next = 1'b0;
    end else if (e2 >= 7'sd31) begin
      res_next = {s1_sign_reg, 5'h1F, 10'h0};
      ovf_next = 1'b1;
      inx_next = 1'b1;
    end else if (e2 <= 7'sd0) begin
      res_next = {s1_sign_reg, 15'h0};
      unf_next = 1'b1;
      inx_next = 1'b1;
    end
  end

  logic        res_valid_reg, ovf_reg, unf_reg, inx_reg, inv_reg;
  logic [15:0] res_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      res_valid_reg <= 1'b0;
      res_reg       <= '0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
      inx_reg       <= 1'b0;
      inv_reg       <= 1'b0;
    end else begin
      res_valid_reg <= s1_valid_reg & ~flush;
      if (s1_valid_reg & ~flush) begin
        res_reg <= res_next;
        ovf_reg <= ovf_next;
        unf_reg <= unf_next;
        inx_reg <= inx_next;
        inv_reg <= inv_next;
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res       = res_reg;
  assign flag_ovf  = ovf_reg;
  assign flag_unf  = unf_reg;
  assign flag_inx  = inx_reg;
  assign flag_inv  = inv_reg;

endmodule

// File: tb/tb_fp16_mul_post.sv
// Directed bench for fp16_mul_post: vector table plus back-to-back, flush and reset sequences.
module tb_fp16_mul_post;

  logic        CLK, RST, flush, op_valid;
  logic [15:0] op_a, op_b;
  logic [9:0]  mul_a, mul_b;
  logic        mul_azero, mul_bzero;
  logic [23:0] mul_s;
  logic        res_valid;
  logic [15:0] res;
  logic        flag_ovf, flag_unf, flag_inx, flag_inv;

  fp16_mul_post dut (
    .CLK(CLK), .RST(RST), .flush(flush), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_azero(mul_azero), .mul_bzero(mul_bzero),
    .mul_s(mul_s), .res_valid(res_valid), .res(res),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx), .flag_inv(flag_inv)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Stand-in for the one-cycle significand multiplier
  always_ff @(posedge CLK)
    mul_s <= {2'b00, 22'({mul_azero, mul_a}) * 22'({mul_bzero, mul_b})};

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // flags packed as {ovf, unf, inx, inv}
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [3:0] flags_now();
    return {flag_ovf, flag_unf, flag_inx, flag_inv};
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(posedge CLK); #1;
    op_valid = 1'b1; op_a = a; op_b = b;
  endtask

  int n;

  initial begin
    vecs[0]  = '{16'h3C00, 16'h4000, 16'h4000, 4'b0000};
    vecs[1]  = '{16'h3E00, 16'h3E00, 16'h4080, 4'b0000};
    vecs[2]  = '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0010};
    vecs[3]  = '{16'h0200, 16'h4800, 16'h0C00, 4'b0000};
    vecs[4]  = '{16'h0400, 16'h3800, 16'h0000, 4'b0110};
    vecs[5]  = '{16'h8400, 16'h3800, 16'h8000, 4'b0110};
    vecs[6]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b1010};
    vecs[7]  = '{16'hFBFF, 16'h7BFF, 16'hFC00, 4'b1010};
    vecs[8]  = '{16'h7C00, 16'h0000, 16'h7E00, 4'b0001};
    vecs[9]  = '{16'hFC00, 16'h3C00, 16'hFC00, 4'b0000};
    vecs[10] = '{16'h7C01, 16'h3C00, 16'h7E00, 4'b0000};
    vecs[11] = '{16'h8000, 16'h3C00, 16'h8000, 4'b0000};
    vecs[12] = '{16'h3C01, 16'h3E00, 16'h3E02, 4'b0010};
    vecs[13] = '{16'h3C03, 16'h3E00, 16'h3E04, 4'b0010};
    vecs[14] = '{16'h0001, 16'h0001, 16'h0000, 4'b0110};
    vecs[15] = '{16'h0400, 16'h3C00, 16'h0400, 4'b0000};
    vecs[16] = '{16'h7800, 16'h3C00, 16'h7800, 4'b0000};
    vecs[17] = '{16'h0000, 16'h7C00, 16'h7E00, 4'b0001};

    RST = 1'b0; flush = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_valid", 32'(res_valid), 32'd0);
    check("reset_res", 32'(res), 32'h0);
    check("reset_flags", 32'(flags_now()), 32'h0);
    RST = 1'b1;

    op_a = 16'h0200; op_b = 16'h4800;
    #1;
    check("mul_a", 32'(mul_a), 32'h200);
    check("mul_b", 32'(mul_b), 32'h000);
    check("mul_azero", 32'(mul_azero), 32'd0);
    check("mul_bzero", 32'(mul_bzero), 32'd1);

    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].a, vecs[i].b);
      @(posedge CLK); #1;
      op_valid = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      $display("vec %0d: %h * %h -> %h flags %b (want %h %b)",
               i, vecs[i].a, vecs[i].b, res, flags_now(), vecs[i].r, vecs[i].f);
      check("vec_valid", 32'(res_valid), 32'd1);
      check("vec_res", 32'(res), 32'(vecs[i].r));
      check("vec_flags", 32'(flags_now()), 32'(vecs[i].f));
    end

    // back-to-back issue
    issue(16'h3C00, 16'h4000);
    @(posedge CLK); #1; op_a = 16'h3E00; op_b = 16'h3E00;
    @(posedge CLK); #1; op_a = 16'h3C01; op_b = 16'h3C01;
    @(posedge CLK); #1; op_valid = 1'b0;
    $display("b2b 0: res %h flags %b", res, flags_now());
    check("b2b0_valid", 32'(res_valid), 32'd1);
    check("b2b0_res", 32'(res), 32'h4000);
    check("b2b0_flags", 32'(flags_now()), 32'h0);
    @(posedge CLK); #1;
    $display("b2b 1: res %h flags %b", res, flags_now());
    check("b2b1_valid", 32'(res_valid), 32'd1);
    check("b2b1_res", 32'(res), 32'h4080);
    check("b2b1_flags", 32'(flags_now()), 32'h0);
    @(posedge CLK); #1;
    $display("b2b 2: res %h flags %b", res, flags_now());
    check("b2b2_valid", 32'(res_valid), 32'd1);
    check("b2b2_res", 32'(res), 32'h3C02);
    check("b2b2_flags", 32'(flags_now()), 32'b0010);
    @(posedge CLK); #1;
    check("b2b_end_valid", 32'(res_valid), 32'd0);
    check("b2b_hold_res", 32'(res), 32'h3C02);
    check("b2b_hold_flags", 32'(flags_now()), 32'b0010);

    // four ops, flush once the second result is visible
    n = 0;
    issue(16'h3C00, 16'h3C00);
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); #1;
      n += int'(res_valid);
      op_valid = (k < 4);
      flush    = (k == 4);
    end
    $display("flush: %0d results observed", n);
    check("flush_count", 32'(n), 32'd2);
    check("flush_end_valid", 32'(res_valid), 32'd0);

    // op_valid coinciding with flush is dropped
    n = 0;
    issue(16'h3C00, 16'h3C00);
    flush = 1'b1;
    @(posedge CLK); #1;
    op_valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      n += int'(res_valid);
    end
    $display("flush+op: %0d results observed", n);
    check("flush_drop", 32'(n), 32'd0);

    // asynchronous reset with three ops in flight
    issue(16'h7C00, 16'h0000);
    @(posedge CLK); #1; op_a = 16'h3C00; op_b = 16'h3C00;
    @(posedge CLK); #1; op_a = 16'h3C00; op_b = 16'h4000;
    @(posedge CLK); #1; op_valid = 1'b0;
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    check("pre_rst_inv", 32'(flag_inv), 32'd1);
    #2; RST = 1'b0;
    #1;
    $display("async reset: valid %b res %h flags %b", res_valid, res, flags_now());
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_res", 32'(res), 32'h0);
    check("rst_flags", 32'(flags_now()), 32'h0);
    @(posedge CLK); #2; RST = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      n += int'(res_valid);
    end
    check("rst_discard", 32'(n), 32'd0);
    issue(16'h3C00, 16'h3C00);
    @(posedge CLK); #1; op_valid = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_early", 32'(res_valid), 32'd0);
    @(posedge CLK); #1;
    $display("post reset: res %h flags %b", res, flags_now());
    check("post_rst_valid", 32'(res_valid), 32'd1);
    check("post_rst_res", 32'(res), 32'h3C00);
    check("post_rst_flags", 32'(flags_now()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
